// File: rtl/regarb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regarb_pkg
// Brief    : Shared widths, requester count and requester-index type for the
//            register-port arbiter.
// Revision : 1.0
// ============================================================================
package regarb_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int SEL_W_DEF  = 3;
    localparam int NREQ       = 2;

    typedef logic [0:0] req_idx_t;

    // A two-requester one-hot grant maps to its index by its upper bit.
    function automatic req_idx_t onehot2idx(input logic [NREQ-1:0] oh);
        return req_idx_t'(oh[1]);
    endfunction
endpackage
`default_nettype wire

// File: rtl/reg_port_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin arbiter with combinational grant and a
//            registered priority pointer.
// Revision : 1.0
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic r_ptr;

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (req == 2'b11) gnt = r_ptr ? 2'b10 : 2'b01;
            else              gnt = req;
        end
    end

    // Priority passes to whichever requester was not just served.
    always_ff @(posedge clk) begin
        if (rst)         r_ptr <= 1'b0;
        else if (gnt[0]) r_ptr <= 1'b1;
        else if (gnt[1]) r_ptr <= 1'b0;
    end
endmodule
`default_nettype wire

// File: rtl/reg_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_port_arbiter
// Brief    : Two-requester write/read port arbiter in front of a register
//            file. Define REGARB_BYPASS_EN for same-cycle write-to-read
//            forwarding.
// Revision : 1.0
// ============================================================================
module reg_port_arbiter
    import regarb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      wr_req,
    input  logic [2*SEL_W-1:0]   wr_sel,
    input  logic [2*DATA_W-1:0]  wr_data,
    output logic [NREQ-1:0]      wr_gnt,
    input  logic [NREQ-1:0]      rd_req,
    input  logic [2*SEL_W-1:0]   rd_sel,
    output logic [NREQ-1:0]      rd_gnt,
    output logic [NREQ-1:0]      rd_valid,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 rf_we,
    output logic [SEL_W-1:0]     rf_sel_in,
    output logic [DATA_W-1:0]    rf_data_in,
    output logic                 rf_oe,
    output logic [SEL_W-1:0]     rf_sel_out,
    input  logic [DATA_W-1:0]    rf_data_out
);
    req_idx_t              w_wr_idx;
    req_idx_t              w_rd_idx;
    logic [SEL_W-1:0]      w_wr_sel;
    logic [DATA_W-1:0]     w_wr_data;
    logic [SEL_W-1:0]      w_rd_sel;
    logic [DATA_W-1:0]     w_rd_src;

    logic                  r_we;
    logic [SEL_W-1:0]      r_wsel;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_oe;
    logic [SEL_W-1:0]      r_rsel;
    logic [NREQ-1:0]       r_rd_p1;
    logic [NREQ-1:0]       r_rd_valid;
    logic [DATA_W-1:0]     r_rd_data;

    rr_arb2 u_wr_arb (.clk(clk), .rst(rst), .req(wr_req), .gnt(wr_gnt));
    rr_arb2 u_rd_arb (.clk(clk), .rst(rst), .req(rd_req), .gnt(rd_gnt));

    assign w_wr_idx  = onehot2idx(wr_gnt);
    assign w_rd_idx  = onehot2idx(rd_gnt);
    assign w_wr_sel  = w_wr_idx[0] ? wr_sel[2*SEL_W-1:SEL_W]    : wr_sel[SEL_W-1:0];
    assign w_wr_data = w_wr_idx[0] ? wr_data[2*DATA_W-1:DATA_W] : wr_data[DATA_W-1:0];
    assign w_rd_sel  = w_rd_idx[0] ? rd_sel[2*SEL_W-1:SEL_W]    : rd_sel[SEL_W-1:0];

`ifdef REGARB_BYPASS_EN
    // The register file only updates at the end of this cycle, so a read
    // issued alongside a same-index write takes the write data directly.
    assign w_rd_src = (r_we && (r_wsel == r_rsel)) ? r_wdata : rf_data_out;
`else
    assign w_rd_src = rf_data_out;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_wsel     <= '0;
            r_wdata    <= '0;
            r_oe       <= 1'b0;
            r_rsel     <= '0;
            r_rd_p1    <= '0;
            r_rd_valid <= '0;
            r_rd_data  <= '0;
        end else begin
            r_we <= |wr_gnt;
            if (|wr_gnt) begin
                r_wsel  <= w_wr_sel;
                r_wdata <= w_wr_data;
            end
            r_oe <= |rd_gnt;
            if (|rd_gnt) r_rsel <= w_rd_sel;
            r_rd_p1    <= rd_gnt;
            r_rd_valid <= r_rd_p1;
            // Capture only while rf_oe is high so a floating bus never lands here.
            r_rd_data  <= (|r_rd_p1) ? w_rd_src : '0;
        end
    end

    assign rf_we      = r_we;
    assign rf_sel_in  = r_wsel;
    assign rf_data_in = r_wdata;
    assign rf_oe      = r_oe;
    assign rf_sel_out = r_rsel;
    assign rd_valid   = rst ? '0 : r_rd_valid;
    assign rd_data    = (rst || (r_rd_valid == '0)) ? '0 : r_rd_data;
endmodule
`default_nettype wire

// File: doc/reg_port_arbiter.md
REG_PORT_ARBITER -- requirements
Module: reg_port_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning register width.
REQ-002 The block SHALL have parameter SEL_W, default 3, meaning register select width (8 registers).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have port wr_req, input, 2, per-requester write request, held until granted.
REQ-006 The block SHALL have port wr_sel, input, 2*SEL_W, per-requester write register index.
REQ-007 The block SHALL have port wr_data, input, 2*DATA_W, per-requester write data.
REQ-008 The block SHALL have port wr_gnt, output, 2, one-hot write grant, combinational, same cycle as the accepted request.
REQ-009 The block SHALL have port rd_req, input, 2, per-requester read request, held until granted.
REQ-010 The block SHALL have port rd_sel, input, 2*SEL_W, per-requester read register index.
REQ-011 The block SHALL have port rd_gnt, output, 2, one-hot read grant, combinational.
REQ-012 The block SHALL have port rd_valid, output, 2, one-cycle pulse marking read return to that requester.
REQ-013 The block SHALL have port rd_data, output, DATA_W, read return data, valid only while any rd_valid bit is high.
REQ-014 The block SHALL have ports rf_we (1), rf_sel_in (SEL_W), rf_data_in (DATA_W), rf_oe (1) and rf_sel_out (SEL_W), all outputs and all registered, driving the register file.
REQ-015 The block SHALL have port rf_data_out, input, DATA_W, the register file read data, which is high-Z when rf_oe is low.

Function
REQ-016 Write and read ports SHALL be arbitrated independently, each by a two-way round-robin with its own priority pointer.
REQ-017 Arbitration: a lone requester is granted; on contention the pointer side wins; after any grant the pointer moves to the other requester.
REQ-018 A write granted in cycle N SHALL drive rf_we=1 and the granted sel/data in N+1, so the register file updates at the end of N+1.
REQ-019 A read granted in cycle N SHALL drive rf_oe=1 and the granted sel in N+1, sample rf_data_out at the end of N+1, and assert rd_valid for the granted requester with rd_data in N+2.
REQ-020 Throughput SHALL be one write grant and one read grant per cycle, with reads pipelined back-to-back.
REQ-021 rf_we and rf_oe SHALL be low in any cycle that follows a cycle without the corresponding grant.
REQ-022 A read granted one or more cycles after a write to the same index SHALL return the new value.
REQ-023 A requester with both wr_req and rd_req high SHALL be granted on each port independently.
REQ-024 rd_data SHALL be 0 when no rd_valid bit is asserted, so an undriven high-Z rf_data_out never propagates.

Reset
REQ-025 While rst is high, every output SHALL be 0 and both round-robin pointers SHALL be 0 (requester 0 has priority).
REQ-026 A rst asserted while reads are in flight SHALL discard them, with no rd_valid after rst.
REQ-027 A rst asserted in the same cycle as a grant SHALL suppress the grant and the following rf_we.

Configuration
REQ-028 Macro REGARB_BYPASS_EN SHALL control same-cycle write-to-read forwarding.
REQ-029 With REGARB_BYPASS_EN defined, a write and a read granted in the same cycle to the same index SHALL return the write data in rd_data.
REQ-030 Without REGARB_BYPASS_EN, a write and a read granted in the same cycle to the same index SHALL return the pre-write register value.

Structure
REQ-031 Package regarb_pkg SHALL hold the DATA_W/SEL_W defaults, NREQ=2 and the requester-index typedef.
REQ-032 Sub-module rr_arb2 (two-way round-robin: req[1:0] in, gnt[1:0] out, internal pointer) SHALL be instantiated twice, once for writes and once for reads.

Verification
REQ-033 Reset: after rst, all outputs are 0; first contention wr_req=2'b11 -> wr_gnt=2'b01, next cycle wr_gnt=2'b10.
REQ-034 Write then read: req0 writes 0xBEEF to index 5 in cycle 0, req1 reads index 5 in cycle 1 -> rd_valid=2'b10, rd_data=0xBEEF in cycle 3.
REQ-035 Same-cycle hazard: index 2 holds 0x1111; write 0x2222 and read index 2 granted together -> rd_data=0x2222 with REGARB_BYPASS_EN, 0x1111 without.
REQ-036 Saturation: both requesters hold rd_req for 8 cycles -> grants alternate 01,10,..., 8 rd_valid pulses each two cycles after its grant, no gap.
REQ-037 Reset mid-read: rst asserted in the cycle after a read grant -> no rd_valid is seen, and rf_oe=0 on the next edge.
